thread_scheduler: RTL and testbench

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

---
 rtl/cpu_config.sv | 6 +
 rtl/cpu_types.sv | 18 +
 rtl/riscv_types.sv | 6 +
 rtl/rr_thread_select.sv | 27 ++
 rtl/thread_scheduler.sv | 127 ++++++++++++
 tb/tb_thread_scheduler.sv | 278 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/cpu_config.sv
// rtl/cpu_config.sv - core-wide configuration constants
package cpu_config;

    localparam int XLEN = 32;

endpackage

// File: rtl/cpu_types.sv
// rtl/cpu_types.sv - hardware-thread types shared by scheduler and register file
package cpu_types;

    localparam int NUM_THREADS = 4;

    typedef logic [1:0] thread_id_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic       valid;
        thread_id_t id;
    } wb_slot_t;

endpackage

// File: rtl/riscv_types.sv
// rtl/riscv_types.sv - architectural register address type
package riscv_types;

    typedef logic [4:0] rs_addr_t;

endpackage

// File: rtl/rr_thread_select.sv
// rtl/rr_thread_select.sv - combinational round-robin pick among eligible threads
module rr_thread_select
    import cpu_types::thread_id_t;
(
    input  logic [3:0] eligible,
    input  thread_id_t last_id,
    output thread_id_t sel_id,
    output logic       sel_valid
);

    thread_id_t cand;

    // Search starts one past the last issued thread and wraps, so last_id is tried last.
    always_comb begin
        sel_id    = last_id;
        sel_valid = 1'b0;
        cand      = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_id + 2'(k);
            if (!sel_valid && eligible[cand]) begin
                sel_valid = 1'b1;
                sel_id    = cand;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// rtl/thread_scheduler.sv - register-file clear sequencer, round-robin issue and writeback tracking
module thread_scheduler
    import cpu_config::*;
    import riscv_types::*;
    import cpu_types::thread_id_t;
    import cpu_types::wb_slot_t;
    import cpu_types::sched_state_t;
    import cpu_types::ST_CLEAR;
    import cpu_types::ST_RUN;
#(
    parameter int NUM_THREADS = cpu_types::NUM_THREADS,
    parameter int WB_LATENCY  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_THREADS-1:0] thread_en,
    input  logic [NUM_THREADS-1:0] thread_stall,
    input  rs_addr_t               wb_rd_addr,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   wb_wr_en,
    output thread_id_t             thread_rs_id,
    output logic                   issue_valid,
    output thread_id_t             thread_rd_id,
    output rs_addr_t               rf_rd_addr,
    output logic [XLEN-1:0]        rf_new_data,
    output logic                   rf_wr_en,
    output logic                   init_done
);

    sched_state_t                 state_q, state_d;
    logic [6:0]                   clr_cnt_q, clr_cnt_d;
    logic                         init_done_q, init_done_d;
    thread_id_t                   last_id_q, last_id_d;
    thread_id_t                   rs_id_q, rs_id_d;
    logic                         issue_valid_q, issue_valid_d;
    wb_slot_t [WB_LATENCY-1:0]    wb_pipe_q, wb_pipe_d;

    logic [3:0] eligible;
    thread_id_t sel_id;
    logic       sel_valid;
    wb_slot_t   tail;

    assign eligible = 4'(thread_en & ~thread_stall);
    assign tail     = wb_pipe_q[WB_LATENCY-1];

    rr_thread_select u_rr_thread_select (
        .eligible  (eligible),
        .last_id   (last_id_q),
        .sel_id    (sel_id),
        .sel_valid (sel_valid)
    );

    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        init_done_d   = init_done_q;
        last_id_d     = last_id_q;
        rs_id_d       = rs_id_q;
        issue_valid_d = 1'b0;
        wb_pipe_d     = wb_pipe_q;

        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 7'd1;
                if (clr_cnt_q == 7'd127) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                issue_valid_d = sel_valid;
                if (sel_valid) begin
                    rs_id_d   = sel_id;
                    last_id_d = sel_id;
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        // Every cycle's issue slot enters the delay line, idle ones included.
        wb_pipe_d[0].valid = issue_valid_q;
        wb_pipe_d[0].id    = rs_id_q;
        for (int i = 1; i < WB_LATENCY; i++) begin
            wb_pipe_d[i] = wb_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_CLEAR;
            clr_cnt_q     <= '0;
            init_done_q   <= 1'b0;
            last_id_q     <= 2'd3;
            rs_id_q       <= '0;
            issue_valid_q <= 1'b0;
            wb_pipe_q     <= '0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            init_done_q   <= init_done_d;
            last_id_q     <= last_id_d;
            rs_id_q       <= rs_id_d;
            issue_valid_q <= issue_valid_d;
            wb_pipe_q     <= wb_pipe_d;
        end
    end

    // rst gates the write strobe so nothing lands in the register file while reset is held.
    always_comb begin
        if (state_q == ST_CLEAR) begin
            rf_wr_en     = ~rst;
            thread_rd_id = clr_cnt_q[6:5];
            rf_rd_addr   = clr_cnt_q[4:0];
            rf_new_data  = '0;
        end else begin
            rf_wr_en     = ~rst & wb_wr_en & tail.valid & (wb_rd_addr != '0);
            thread_rd_id = tail.id;
            rf_rd_addr   = wb_rd_addr;
            rf_new_data  = wb_data;
        end
    end

    assign thread_rs_id = rs_id_q;
    assign issue_valid  = issue_valid_q;
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// tb/tb_thread_scheduler.sv - randomized and directed bench for thread_scheduler
module tb_thread_scheduler;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  thread_en;
    logic [3:0]  thread_stall;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        wb_wr_en;
    logic [1:0]  thread_rs_id;
    logic        issue_valid;
    logic [1:0]  thread_rd_id;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_new_data;
    logic        rf_wr_en;
    logic        init_done;

    always #5 clk = ~clk;

    thread_scheduler #(.NUM_THREADS(4), .WB_LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .thread_en    (thread_en),
        .thread_stall (thread_stall),
        .wb_rd_addr   (wb_rd_addr),
        .wb_data      (wb_data),
        .wb_wr_en     (wb_wr_en),
        .thread_rs_id (thread_rs_id),
        .issue_valid  (issue_valid),
        .thread_rd_id (thread_rd_id),
        .rf_rd_addr   (rf_rd_addr),
        .rf_new_data  (rf_new_data),
        .rf_wr_en     (rf_wr_en),
        .init_done    (init_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: clear progress, run flag, pointer, current issue and issue history.
    int clr_idx;
    bit m_run;
    int m_ptr;
    bit m_iv;
    int m_id;
    bit hist_v[$];
    int hist_id[$];

    logic [1:0] obs_rs, obs_rd;
    logic       obs_iv, obs_wr, obs_init;
    logic [4:0] obs_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        clr_idx = 0;
        m_run   = 1'b0;
        m_ptr   = 3;
        m_iv    = 1'b0;
        m_id    = 0;
        hist_v.delete();
        hist_id.delete();
        for (int i = 0; i < LAT; i++) begin
            hist_v.push_back(1'b0);
            hist_id.push_back(0);
        end
    endtask

    task automatic rand_wb();
        wb_wr_en   = 1'($urandom_range(0, 1));
        wb_rd_addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        wb_data    = $urandom;
    endtask

    // Called at the falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        bit tv;
        int tid;
        bit exp_wr;
        bit found;
        int cand;
        #1;
        tv  = hist_v[hist_v.size() - LAT];
        tid = hist_id[hist_id.size() - LAT];
        if (!m_run) begin
            chk("clr_wr_en", rf_wr_en, !rst);
            chk("clr_addr", rf_rd_addr, clr_idx % 32);
            chk("clr_tid", thread_rd_id, clr_idx / 32);
            chk("clr_data", rf_new_data, 0);
            chk("clr_issue_valid", issue_valid, 0);
            chk("clr_init_done", init_done, 0);
        end else begin
            exp_wr = !rst && wb_wr_en && tv && (wb_rd_addr != 0);
            chk("run_init_done", init_done, 1);
            chk("run_issue_valid", issue_valid, m_iv);
            chk("run_rs_id", thread_rs_id, m_id);
            chk("run_wr_en", rf_wr_en, exp_wr);
            if (tv) chk("run_rd_id", thread_rd_id, tid);
            chk("run_wr_addr", rf_rd_addr, wb_rd_addr);
            chk("run_wr_data", rf_new_data, wb_data);
        end
        obs_rs   = thread_rs_id;
        obs_rd   = thread_rd_id;
        obs_iv   = issue_valid;
        obs_wr   = rf_wr_en;
        obs_init = init_done;
        obs_addr = rf_rd_addr;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            hist_v.push_back(m_iv);
            hist_id.push_back(m_id);
            if (hist_v.size() > 2 * LAT + 2) begin
                void'(hist_v.pop_front());
                void'(hist_id.pop_front());
            end
            if (!m_run) begin
                clr_idx++;
                if (clr_idx == 128) m_run = 1'b1;
            end else begin
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    cand = (m_ptr + k) % 4;
                    if (!found && thread_en[cand] && !thread_stall[cand]) begin
                        found = 1'b1;
                        m_id  = cand;
                        m_ptr = cand;
                    end
                end
                m_iv = found;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int wr_count;
        int p;
        int seq26 [6];
        int exp26 [6];
        exp26 = '{1, 1, 1, 3, 1, 3};

        rst = 1'b1; thread_en = 4'b1111; thread_stall = 4'b0000;
        wb_wr_en = 1'b0; wb_rd_addr = '0; wb_data = '0;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset held: no writes, no issue
        cycle();
        chk("reset_wr_en", obs_wr, 0);
        rst = 1'b0;

        // Full clear sequence with write requests that must be ignored
        wr_count = 0;
        for (int i = 0; i < 128; i++) begin
            rand_wb();
            cycle();
            if (obs_wr) wr_count++;
        end
        chk("clear_write_count", wr_count, 128);
        chk("init_done_cycle129", init_done, 1);

        // All threads enabled: 0,1,2,3,... and writeback ids LAT cycles later
        wb_wr_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (i >= 1) begin
                chk("rr_all_valid", obs_iv, 1);
                chk("rr_all_id", obs_rs, (i - 1) % 4);
            end
            if (i >= 1 + LAT) chk("rr_all_rd_id", obs_rd, (i - 1 - LAT) % 4);
        end

        // Threads 1 and 3 enabled, thread 3 stalled for two cycles
        thread_en = 4'b0010; thread_stall = 4'b0000;
        cycle();
        thread_en = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            thread_stall = (i < 2) ? 4'b1000 : 4'b0000;
            cycle();
            seq26[i] = obs_rs;
            chk("stall_seq_valid", obs_iv, 1);
        end
        for (int i = 0; i < 6; i++) chk("stall_seq_id", seq26[i], exp26[i]);

        // Register-0 write suppression and normal write with a live tail
        thread_en = 4'b1111; thread_stall = 4'b0000;
        for (int i = 0; i < 4; i++) cycle();
        wb_wr_en = 1'b1; wb_rd_addr = 5'd0; wb_data = 32'hDEADBEEF;
        cycle();
        chk("x0_suppressed", obs_wr, 0);
        wb_rd_addr = 5'd5;
        cycle();
        chk("x5_write_en", obs_wr, 1);
        chk("x5_write_addr", obs_addr, 5);

        // All stalled for four cycles: idle slots drop writebacks, then resume at pointer+1
        wb_wr_en = 1'b0;
        thread_stall = 4'b1111;
        cycle();
        p = obs_rs;
        for (int i = 0; i < 3; i++) cycle();
        thread_stall = 4'b0000; wb_wr_en = 1'b1; wb_rd_addr = 5'd7;
        cycle();
        chk("idle_issue_valid", obs_iv, 0);
        chk("idle_wb_dropped", obs_wr, 0);
        cycle();
        chk("idle_wb_dropped2", obs_wr, 0);
        chk("resume_valid", obs_iv, 1);
        chk("resume_id", obs_rs, (p + 1) % 4);

        // Randomized run traffic
        for (int i = 0; i < 250; i++) begin
            thread_en    = 4'($urandom);
            thread_stall = 4'($urandom) & 4'($urandom);
            rand_wb();
            cycle();
        end

        // Reset mid-run restarts the full clear
        rst = 1'b1;
        rand_wb();
        cycle();
        chk("midrun_reset_wr_en", obs_wr, 0);
        rst = 1'b0;
        for (int i = 0; i < 130; i++) begin
            thread_en = 4'($urandom); thread_stall = 4'($urandom);
            rand_wb();
            cycle();
        end

        // Reset at clear counter 60
        for (int i = 0; i < 140; i++) begin
            rand_wb();
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 60; i++) cycle();
        rst = 1'b1;
        cycle();
        chk("clr60_reset_wr_en", obs_wr, 0);
        rst = 1'b0;
        cycle();
        chk("clr60_restart_wr", obs_wr, 1);
        chk("clr60_restart_addr", obs_addr, 0);
        wr_count = 0;
        for (int i = 0; i < 127; i++) begin
            cycle();
            if (obs_init) wr_count++;
        end
        chk("clr60_init_low_cycles", wr_count, 0);
        chk("clr60_init_done", init_done, 1);

        for (int i = 0; i < 150; i++) begin
            thread_en    = 4'($urandom);
            thread_stall = 4'($urandom) & 4'($urandom);
            rand_wb();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
